// File: rtl/dmem_sram_responder.sv
// dmem_sram_responder
//   Responder end of the CPU's sram-like data-memory port, backed by an
//   on-chip word-organised RAM of 2**ADDR_W 32-bit words. One outstanding
//   request at a time. The response arrives LATENCY cycles after the accept.
//   ADDR_OK_GAP idle cycles follow each response before a new accept is allowed.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset (RAM contents are kept)
//   data_req      request valid
//   data_wr       1 = write, 0 = read
//   data_size     0 byte, 1 half, 2/3 word
//   data_addr     byte address; bits above ADDR_W+1 ignored (RAM aliases)
//   data_wdata    lane-replicated write data
//   data_addr_ok  accept strobe (accept = data_req && data_addr_ok)
//   data_data_ok  one-cycle response pulse
//   data_rdata    full aligned read word, held until the next read response

module dmem_sram_responder #(
    parameter int ADDR_W      = 12,
    parameter int LATENCY     = 2,
    parameter int ADDR_OK_GAP = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;

    // Counter reload values; the GAP reload is unused when ADDR_OK_GAP == 0.
    localparam logic [3:0] LAT_LD = 4'(LATENCY - 1);
    localparam logic [3:0] GAP_LD = (ADDR_OK_GAP == 0) ? 4'd0 : 4'(ADDR_OK_GAP - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] hold_q;

    logic [31:0] mem [0:(2**ADDR_W)-1];

    logic              accept;
    logic              resp_fire;
    logic [3:0]        be;
    logic [ADDR_W-1:0] widx;

    // Address bits above the RAM index do not take part in decoding.
    logic unused_addr_hi;
    assign unused_addr_hi = ^data_addr[31:ADDR_W+2];

    assign widx      = data_addr[ADDR_W+1:2];
    assign accept    = (state_q == S_IDLE) && data_req && !rst;
    assign resp_fire = (state_q == S_WAIT) && (cnt_q == 4'd0) && !rst;

    always_comb begin
        be = 4'b1111;
        case (data_size)
            2'd0:    be = 4'b0001 << data_addr[1:0];
            2'd1:    be = data_addr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // RAM: writes commit at the accept edge; reads sample the word at the
    // accept edge into hold_q. Serialized accepts give read-after-write.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (data_wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[widx][8*i +: 8] <= data_wdata[8*i +: 8];
                end
            end else begin
                hold_q <= mem[widx];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        case (state_q)
            S_IDLE: begin
                data_addr_ok = !rst;
                if (data_req) begin
                    wr_d    = data_wr;
                    cnt_d   = LAT_LD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_data_ok = !rst;
                    if (ADDR_OK_GAP == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = GAP_LD;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == 4'd0) state_d = S_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The read word is presented combinationally in the data_ok cycle and
    // captured so it holds until the next read response.
    assign rdata_d    = (resp_fire && !wr_q) ? hold_q : rdata_q;
    assign data_rdata = rdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_sram_responder.sv
module tb_dmem_sram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, wr;
    logic [1:0]  sz;
    logic [31:0] addr, wdata;
    logic        aok_a, dok_a, aok_b, dok_b;
    logic [31:0] rd_a, rd_b;

    int vectors = 0;
    int miscompares = 0;

    // A: LATENCY=2, no gap.  B: LATENCY=1, ADDR_OK_GAP=3. Inputs are shared.
    dmem_sram_responder #(.ADDR_W(12), .LATENCY(2), .ADDR_OK_GAP(0)) u_a (
        .clk(clk), .rst(rst), .data_req(req), .data_wr(wr), .data_size(sz),
        .data_addr(addr), .data_wdata(wdata),
        .data_addr_ok(aok_a), .data_data_ok(dok_a), .data_rdata(rd_a)
    );

    dmem_sram_responder #(.ADDR_W(12), .LATENCY(1), .ADDR_OK_GAP(3)) u_b (
        .clk(clk), .rst(rst), .data_req(req), .data_wr(wr), .data_size(sz),
        .data_addr(addr), .data_wdata(wdata),
        .data_addr_ok(aok_b), .data_data_ok(dok_b), .data_rdata(rd_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction on instance A, starting in IDLE at the next negedge.
    task automatic xact_a(input logic w, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] r);
        int n;
        @(negedge clk);
        chk("a_idle_aok", 32'(aok_a), 32'd1);
        req = 1'b1; wr = w; sz = s; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
        n = 1;
        while (!dok_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("a_latency", 32'(n), 32'd2);
        chk("a_aok_in_dok", 32'(aok_a), 32'd0);
        r = rd_a;
    endtask

    task automatic wait_b_idle();
        int n;
        n = 0;
        while (!aok_b && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b_idle", 32'(aok_b), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        rst = 1'b1; req = 1'b0; wr = 1'b0; sz = 2'd0; addr = 32'd0; wdata = 32'd0;

        // reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_aok", 32'(aok_a), 32'd0);
            chk("rst_dok", 32'(dok_a), 32'd0);
            chk("rst_rdata", rd_a, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_aok_a", 32'(aok_a), 32'd1);
        chk("post_rst_aok_b", 32'(aok_b), 32'd1);

        // word write then read
        xact_a(1'b1, 2'd2, 32'h100, 32'hDEADBEEF, r);
        xact_a(1'b0, 2'd2, 32'h100, 32'h0, r);
        chk("rd_word", r, 32'hDEADBEEF);

        // byte / half merge
        xact_a(1'b1, 2'd2, 32'h100, 32'h11223344, r);
        chk("rdata_hold_on_wr", r, 32'hDEADBEEF);
        xact_a(1'b1, 2'd0, 32'h101, 32'hAAAAAAAA, r);
        xact_a(1'b1, 2'd1, 32'h102, 32'h55555555, r);
        xact_a(1'b0, 2'd2, 32'h100, 32'h0, r);
        chk("rd_merge", r, 32'h5555AA44);

        // size 3 as word, half with addr[0] set, top byte lane
        xact_a(1'b1, 2'd3, 32'h200, 32'hCAFEF00D, r);
        xact_a(1'b0, 2'd2, 32'h200, 32'h0, r);
        chk("rd_size3", r, 32'hCAFEF00D);
        xact_a(1'b1, 2'd1, 32'h201, 32'h0000BEEF, r);
        xact_a(1'b0, 2'd2, 32'h200, 32'h0, r);
        chk("rd_half_a0", r, 32'hCAFEBEEF);
        xact_a(1'b1, 2'd0, 32'h203, 32'h77000000, r);
        xact_a(1'b0, 2'd2, 32'h200, 32'h0, r);
        chk("rd_byte3", r, 32'h77FEBEEF);

        // aliasing
        xact_a(1'b1, 2'd2, 32'h4000, 32'h12345678, r);
        xact_a(1'b0, 2'd2, 32'h0000, 32'h0, r);
        chk("rd_alias0", r, 32'h12345678);
        xact_a(1'b0, 2'd2, 32'h4100, 32'h0, r);
        chk("rd_alias100", r, 32'h5555AA44);

        // B: req held high -> accepts every LATENCY+1+GAP = 5 cycles
        @(negedge clk);
        wait_b_idle();
        req = 1'b1; wr = 1'b0; sz = 2'd2; addr = 32'h0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("b_aok_k%0d", k), 32'(aok_b), 32'((k % 5) == 0));
            chk($sformatf("b_dok_k%0d", k), 32'(dok_b), 32'((k % 5) == 1));
            @(negedge clk);
        end
        req = 1'b0;

        // B: reset in the data_ok cycle drops the response
        @(negedge clk);
        wait_b_idle();
        req = 1'b1; wr = 1'b0; addr = 32'h100;
        @(posedge clk);
        #1;
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        chk("b_dok_in_rst", 32'(dok_b), 32'd0);
        chk("b_aok_in_rst", 32'(aok_b), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("b_dok_after_rst", 32'(dok_b), 32'd0);
            if (k == 0) begin
                chk("b_aok_after_rst", 32'(aok_b), 32'd1);
                chk("b_rdata_after_rst", rd_b, 32'd0);
            end
        end

        // RAM survives reset
        xact_a(1'b0, 2'd2, 32'h100, 32'h0, r);
        chk("rd_after_rst", r, 32'h5555AA44);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
